// File: rtl/i2c_cmd_arbiter_if.sv
// Requester, status and engine-side signals of the I2C command arbiter.
// The arbiter uses the slave modport; the environment driving it uses master.
interface i2c_cmd_arbiter_if;
   logic [1:0]  req;
   logic [23:0] cmd0;
   logic [23:0] cmd1;
   logic [1:0]  done;
   logic [1:0]  err;
   logic        busy;
   logic        eng_start;
   logic [23:0] eng_cmd;
   logic        eng_abort;
   logic        eng_done;
   logic        eng_nack;

   modport slave (
      input  req, cmd0, cmd1, eng_done, eng_nack,
      output done, err, busy, eng_start, eng_cmd, eng_abort
   );

   modport master (
      output req, cmd0, cmd1, eng_done, eng_nack,
      input  done, err, busy, eng_start, eng_cmd, eng_abort
   );
endinterface

// File: rtl/i2c_cmd_arbiter.sv
// Round-robin arbiter handing 24-bit CODEC commands from two requesters to one I2C write engine.
// Define CMD_RETRY_EN to re-issue NACKed commands up to MAX_RETRY times before reporting err.
module i2c_cmd_arbiter #(
   parameter int unsigned MAX_RETRY   = 3,
   parameter int unsigned GAP_CYC     = 1024,
   parameter int unsigned TIMEOUT_CYC = 262143
) (
   input logic              clk,
   input logic              rst_n,
   i2c_cmd_arbiter_if.slave bus
);
   localparam int unsigned GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_e;

   state_e        state_q, state_d;
   // The last-grant pointer doubles as the owner of the transaction in flight.
   logic          last_q, last_d;
   logic [23:0]   cmd_q, cmd_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [TW-1:0] to_q, to_d;
   logic [1:0]    done_q, done_d;
   logic [1:0]    err_q, err_d;
   logic          abort_q, abort_d;
   logic          start_q, busy_q;
   logic          grant;
   logic          retry_now;

`ifdef CMD_RETRY_EN
   localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

   logic [RW-1:0] rcnt_q, rcnt_d;
   logic          retry_q, retry_d;
`endif

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      cmd_d     = cmd_q;
      gap_d     = gap_q;
      to_d      = to_q;
      done_d    = '0;
      err_d     = '0;
      abort_d   = 1'b0;
      grant     = 1'b0;
      retry_now = 1'b0;
`ifdef CMD_RETRY_EN
      rcnt_d    = rcnt_q;
      retry_d   = retry_q;
      retry_now = bus.eng_nack && (rcnt_q < RETRY_MAX);
`endif
      unique case (state_q)
         IDLE: begin
            if (bus.req != 2'b00) begin
               grant   = (bus.req == 2'b11) ? ~last_q : bus.req[1];
               last_d  = grant;
               cmd_d   = grant ? bus.cmd1 : bus.cmd0;
`ifdef CMD_RETRY_EN
               rcnt_d  = '0;
`endif
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            to_d    = '0;
            state_d = WAIT;
         end
         WAIT: begin
            // A completion on the final timeout cycle takes priority over the abort.
            if (bus.eng_done) begin
               gap_d   = '0;
               state_d = GAP;
               if (retry_now) begin
`ifdef CMD_RETRY_EN
                  rcnt_d  = rcnt_q + RW'(1);
                  retry_d = 1'b1;
`endif
               end else if (bus.eng_nack) begin
                  err_d[last_q] = 1'b1;
               end else begin
                  done_d[last_q] = 1'b1;
               end
            end else if (to_q == TO_LAST) begin
               abort_d       = 1'b1;
               err_d[last_q] = 1'b1;
               gap_d         = '0;
               state_d       = GAP;
            end else begin
               to_d = to_q + TW'(1);
            end
         end
         GAP: begin
            if (gap_q == GAP_LAST) begin
               state_d = IDLE;
`ifdef CMD_RETRY_EN
               if (retry_q) begin
                  state_d = ISSUE;
                  retry_d = 1'b0;
               end
`endif
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         cmd_q   <= '0;
         gap_q   <= '0;
         to_q    <= '0;
         done_q  <= '0;
         err_q   <= '0;
         abort_q <= 1'b0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         cmd_q   <= cmd_d;
         gap_q   <= gap_d;
         to_q    <= to_d;
         done_q  <= done_d;
         err_q   <= err_d;
         abort_q <= abort_d;
         start_q <= (state_d == ISSUE);
         busy_q  <= (state_d != IDLE);
      end
   end

`ifdef CMD_RETRY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rcnt_q  <= '0;
         retry_q <= 1'b0;
      end else begin
         rcnt_q  <= rcnt_d;
         retry_q <= retry_d;
      end
   end
`endif

   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.busy      = busy_q;
   assign bus.eng_start = start_q;
   assign bus.eng_cmd   = cmd_q;
   assign bus.eng_abort = abort_q;
endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Bench for i2c_cmd_arbiter: a transaction-level timeline model precomputes every input and
// expected output per cycle; the drive and compare processes then replay it against the DUT.
module tb_i2c_cmd_arbiter;
   localparam int unsigned MAXR = 3;
   localparam int unsigned GAP  = 1024;
   localparam int unsigned TMO  = 100;
   localparam int          NCYC = 80000;
`ifdef CMD_RETRY_EN
   localparam bit RETRY_EN = 1'b1;
`else
   localparam bit RETRY_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   i2c_cmd_arbiter_if bus();

   i2c_cmd_arbiter #(
      .MAX_RETRY  (MAXR),
      .GAP_CYC    (GAP),
      .TIMEOUT_CYC(TMO)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   // Stimulus timeline
   bit        rst_tl   [NCYC];
   bit [1:0]  req_tl   [NCYC];
   bit [23:0] c0_tl    [NCYC];
   bit [23:0] c1_tl    [NCYC];
   bit        edone_tl [NCYC];
   bit        enack_tl [NCYC];
   // Expected outputs per cycle
   bit        x_start  [NCYC];
   bit        x_abort  [NCYC];
   bit        x_busy   [NCYC];
   bit [1:0]  x_done   [NCYC];
   bit [1:0]  x_err    [NCYC];
   bit [23:0] x_cmd    [NCYC];

   // Model state: first free IDLE cycle, last grant, held requests
   int        t;
   bit        last;
   bit [1:0]  pend;
   int        rise [2];
   bit [23:0] pcmd [2];
   bit        noise;
   int        end_cyc;

   int n_vec  = 0;
   int n_miss = 0;

   task automatic drop(input int p, input int d);
      for (int c = rise[p]; c < d; c++) begin
         req_tl[c][p] = 1'b1;
         if (p == 0) c0_tl[c] = pcmd[0];
         else        c1_tl[c] = pcmd[1];
      end
      pend[p] = 1'b0;
   endtask

   task automatic set_busy(input int a, input int b);
      for (int c = a; c < b; c++) x_busy[c] = 1'b1;
   endtask

   task automatic set_cmd(input int from, input bit [23:0] v);
      for (int c = from; c < NCYC; c++) x_cmd[c] = v;
   endtask

   function automatic int rnd_dl();
      case ($urandom_range(9))
         0:       return int'(TMO);
         1:       return int'(TMO) + 1;
         2:       return int'(TMO) - 1;
         3:       return 400;
         default: return int'($urandom_range(1, 60));
      endcase
   endfunction

   // One granted command: engine answers attempt a after dlN cycles (beyond TMO = hang).
   task automatic txn(input bit [1:0] add, input int w, input bit [23:0] c0, input bit [23:0] c1,
                      input int dl0, input int dl1, input int dl2, input int dl3,
                      input bit [3:0] nk, input bit early, input int rst_off);
      int dl [4];
      int g, s, r, x, owner, q;
      bit fail, to, retry, dropped;
      dl = '{dl0, dl1, dl2, dl3};
      for (int p = 0; p < 2; p++) begin
         if (add[p] && !pend[p]) begin
            pend[p] = 1'b1;
            rise[p] = t + w;
            pcmd[p] = (p == 0) ? c0 : c1;
         end
      end
      g = t;
      while (!((pend[0] && rise[0] <= g) || (pend[1] && rise[1] <= g)) && g < NCYC) g++;
      if (pend[0] && rise[0] <= g && pend[1] && rise[1] <= g) owner = last ? 0 : 1;
      else owner = (pend[1] && rise[1] <= g) ? 1 : 0;
      last = owner[0];
      set_cmd(g + 1, pcmd[owner]);
      s = g + 1;
      dropped = 1'b0;
      for (int a = 0; a < 4; a++) begin
         x_start[s] = 1'b1;
         if (rst_off >= 0) begin
            x = s + rst_off;
            set_busy(s, x);
            rst_tl[x] = 1'b0;
            rst_tl[x + 1] = 1'b0;
            set_cmd(x, 24'h0);
            for (int p = 0; p < 2; p++) if (pend[p]) drop(p, x);
            last = 1'b1;
            t = x + 2;
            return;
         end
         if (noise && $urandom_range(3) == 0) begin
            edone_tl[s] = 1'b1;
            enack_tl[s] = 1'($urandom_range(1));
         end
         if (dl[a] <= int'(TMO)) begin
            edone_tl[s + dl[a]] = 1'b1;
            enack_tl[s + dl[a]] = nk[a];
            r = s + dl[a] + 1;
            to = 1'b0;
            fail = nk[a];
         end else begin
            r = s + int'(TMO) + 1;
            to = 1'b1;
            fail = 1'b1;
            x_abort[r] = 1'b1;
            if (dl[a] < int'(TMO + GAP)) begin
               edone_tl[s + dl[a]] = 1'b1;
               enack_tl[s + dl[a]] = 1'($urandom_range(1));
            end
         end
         retry = !to && fail && RETRY_EN && (a < int'(MAXR));
         if (early && !dropped) begin
            drop(owner, s + 1);
            dropped = 1'b1;
         end
         set_busy(s, r + int'(GAP));
         if (retry) begin
            s = r + int'(GAP);
            continue;
         end
         if (fail) x_err[r][owner]  = 1'b1;
         else      x_done[r][owner] = 1'b1;
         if (!dropped) drop(owner, r);
         if (noise) begin
            edone_tl[r + 3] = 1'b1;
            enack_tl[r + 3] = 1'($urandom_range(1));
            q = int'($urandom_range(1));
            if (!pend[q]) for (int c = r + 5; c < r + 9; c++) req_tl[c][q] = 1'b1;
         end
         t = r + int'(GAP);
         return;
      end
   endtask

   task automatic gen();
      for (int c = 0; c < NCYC; c++) begin
         rst_tl[c] = (c >= 3);
         c0_tl[c]  = 24'($urandom);
         c1_tl[c]  = 24'($urandom);
      end
      t = 3; last = 1'b1; pend = 2'b00; noise = 1'b0;
      txn(2'b01, 0, 24'h341E00, 24'h0, 40, 40, 40, 40, 4'b0000, 1'b0, -1);
      // reset while WAITing, then a lone port 1 request
      txn(2'b01, 2, 24'h0A0B0C, 24'h0, 1000, 1000, 1000, 1000, 4'b0000, 1'b0, 5);
      txn(2'b10, 0, 24'h0, 24'h1A2B3C, 30, 30, 30, 30, 4'b0000, 1'b0, -1);
      // round robin on ties
      txn(2'b11, 0, 24'h111111, 24'h222222, 20, 20, 20, 20, 4'b0000, 1'b0, -1);
      txn(2'b00, 0, 24'h0, 24'h0, 25, 25, 25, 25, 4'b0000, 1'b0, -1);
      txn(2'b11, 1, 24'h333333, 24'h444444, 15, 15, 15, 15, 4'b0000, 1'b0, -1);
      txn(2'b00, 0, 24'h0, 24'h0, 15, 15, 15, 15, 4'b0000, 1'b0, -1);
      // NACK on every attempt, then NACK-NACK-ACK
      txn(2'b01, 0, 24'h555555, 24'h0, 10, 20, 30, 40, 4'b1111, 1'b0, -1);
      txn(2'b10, 0, 24'h0, 24'h666666, 10, 20, 30, 40, 4'b0011, 1'b0, -1);
      // hang, done exactly on the last WAIT cycle, then a normal request
      txn(2'b01, 0, 24'h777777, 24'h0, 500, 500, 500, 500, 4'b0000, 1'b0, -1);
      txn(2'b10, 0, 24'h0, 24'h888888, int'(TMO), 5, 5, 5, 4'b0000, 1'b0, -1);
      txn(2'b01, 0, 24'h999999, 24'h0, 50, 50, 50, 50, 4'b0000, 1'b1, -1);
      noise = 1'b1;
      for (int i = 0; i < 10 && t < NCYC - 12000; i++) begin
         bit [1:0] add;
         add = 2'($urandom_range(3));
         if (pend == 2'b00 && add == 2'b00) add = 2'($urandom_range(1, 3));
         txn(add, int'($urandom_range(0, 3)), 24'($urandom), 24'($urandom),
             rnd_dl(), rnd_dl(), rnd_dl(), rnd_dl(), 4'($urandom), $urandom_range(3) == 0, -1);
      end
      while (pend != 2'b00)
         txn(2'b00, 0, 24'h0, 24'h0, rnd_dl(), rnd_dl(), rnd_dl(), rnd_dl(), 4'($urandom), 1'b0, -1);
      end_cyc = t + 5;
   endtask

   task automatic drive();
      for (int c = 0; c <= end_cyc; c++) begin
         @(posedge clk);
         #1;
         rst_n        = rst_tl[c];
         bus.req      = req_tl[c];
         bus.cmd0     = c0_tl[c];
         bus.cmd1     = c1_tl[c];
         bus.eng_done = edone_tl[c];
         bus.eng_nack = enack_tl[c];
      end
   endtask

   task automatic chk(input string nm, input int c, input logic [23:0] act, input logic [23:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s cycle %0d: got %h, expected %h", nm, c, act, exp);
      end
   endtask

   task automatic compare();
      for (int c = 0; c <= end_cyc; c++) begin
         @(negedge clk);
         chk("eng_start", c, 24'(bus.eng_start), 24'(x_start[c]));
         chk("eng_abort", c, 24'(bus.eng_abort), 24'(x_abort[c]));
         chk("busy",      c, 24'(bus.busy),      24'(x_busy[c]));
         chk("done",      c, 24'(bus.done),      24'(x_done[c]));
         chk("err",       c, 24'(bus.err),       24'(x_err[c]));
         chk("eng_cmd",   c, bus.eng_cmd,        x_cmd[c]);
         // Hand-derived anchors for the opening directed transactions
         if (c == 4) begin
            chk("t1_start", c, 24'(bus.eng_start), 24'd1);
            chk("t1_cmd",   c, bus.eng_cmd, 24'h341E00);
         end
         if (c == 45)   chk("t1_done",     c, 24'(bus.done), 24'd1);
         if (c == 1068) chk("t1_busy_gap", c, 24'(bus.busy), 24'd1);
         if (c == 1069) chk("t1_busy_off", c, 24'(bus.busy), 24'd0);
         if (c == 1076) chk("rst_busy_pre", c, 24'(bus.busy), 24'd1);
         if (c == 1077) begin
            chk("rst_busy", c, 24'(bus.busy), 24'd0);
            chk("rst_cmd",  c, bus.eng_cmd, 24'h0);
         end
         if (c == 1080) chk("p1_start", c, 24'(bus.eng_start), 24'd1);
         if (c == 1111) chk("p1_done",  c, 24'(bus.done), 24'd2);
      end
   endtask

   initial begin
      rst_n        = 1'b0;
      bus.req      = 2'b00;
      bus.cmd0     = 24'h0;
      bus.cmd1     = 24'h0;
      bus.eng_done = 1'b0;
      bus.eng_nack = 1'b0;
      gen();
      fork
         drive();
         compare();
      join
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule

// File: doc/i2c_cmd_arbiter.md
# i2c_cmd_arbiter

Shares the single three-byte I2C write engine that programs the audio CODEC between two command requesters: port 0 (boot-time configuration sequencer) and port 1 (runtime controls such as volume or mute). The arbiter grants requesters round-robin and hands one 24-bit command (address, register, data) to the engine. It enforces a bus-free gap between transactions, retries NACKed commands, and reports completion or failure per port.

## Interface
- MAX_RETRY, default 3: re-issues allowed after a NACK (total attempts = MAX_RETRY+1).
- GAP_CYC, default 1024: idle clk cycles enforced after every engine transaction.
- TIMEOUT_CYC, default 262143: clk cycles in WAIT before the engine is declared hung.
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  2  per-port request; hold high with cmd stable until that port's done/err.
- cmd0  input  24  port 0 command {dev_addr, reg, data}.
- cmd1  input  24  port 1 command.
- done  output  2  one-cycle pulse: the owner's command was ACKed.
- err  output  2  one-cycle pulse: the owner's command failed (NACK after all retries, or timeout).
- busy  output  1  high whenever the state is not IDLE.
- eng_start  output  1  one-cycle start strobe to the engine.
- eng_cmd  output  24  latched command; stable from ISSUE until the return to IDLE.
- eng_abort  output  1  one-cycle pulse on timeout; the engine releases SDA/SCL.
- eng_done  input  1  one-cycle engine completion pulse.
- eng_nack  input  1  qualified by eng_done; 1 means any byte was NACKed.

## Operation
- States: IDLE, ISSUE, WAIT, GAP.
- IDLE:
  - If any req bit is set, grant, latch the owner and cmdN into eng_cmd, clear retry_cnt, go to ISSUE.
  - Tie: grant the port not granted last. The last-grant pointer resets to 1, so port 0 wins the first tie.
- ISSUE: eng_start=1 for exactly one cycle, clear the timeout counter, go to WAIT.
- WAIT, on eng_done=1:
  - eng_nack=1 and retry_cnt<MAX_RETRY: retry_cnt++, set the retry flag, go to GAP. No done/err pulse.
  - Otherwise: set done[owner] if eng_nack=0, or err[owner] if eng_nack=1. Go to GAP.
- WAIT, timeout: the counter reaches TIMEOUT_CYC with no eng_done. Pulse eng_abort and err[owner], no retry, go to GAP.
- GAP: count GAP_CYC cycles. At the end go to ISSUE if the retry flag is set (and clear the flag), else IDLE.
- req deasserted before grant: the request is abandoned.
- req deasserted after grant: ignored. The transaction completes and the done/err pulse is still issued.
- eng_done outside WAIT is ignored.
- eng_done on the same cycle the timeout count hits TIMEOUT_CYC: eng_done wins, no abort.
- A requester must not reassert for a new command in the same cycle as its done/err pulse. It may reassert on the following cycle.
- Counters are sized by $clog2 of their parameter. The gap and timeout counters saturate and never wrap.

## Timing
- Reset values: done=0, err=0, busy=0, eng_start=0, eng_abort=0, eng_cmd=24'h0. State=IDLE, pointer=1, all counters 0.
- All outputs are registered.
- Grant latency: req sampled high at edge k gives eng_start high in cycle k+1 and busy high from k+1.
- Response latency: eng_done high at edge m gives done/err high in cycle m+1, for one cycle.
- Back-to-back throughput: the next grant can occur no earlier than GAP_CYC+1 cycles after the response pulse.
- Reset mid-transaction: all state clears immediately. No done/err is issued for the aborted command, and eng_abort is not pulsed.

## Configuration
- CMD_RETRY_EN defined: NACK retry behaves as described above.
- CMD_RETRY_EN undefined:
  - retry_cnt and the retry flag are removed and MAX_RETRY is ignored.
  - Any NACK immediately produces err[owner], then GAP, then IDLE.

## Test plan
- Reset, then req=2'b01, cmd0=24'h34_1E_00, engine ACKs 40 cycles after start → eng_cmd=24'h341E00, eng_start one cycle after req, done=2'b01 one cycle after eng_done, busy low after 1024 gap cycles.
- req=2'b11 from reset, both ACKed → port 0 served first, then port 1 (round-robin). Hold both high again → port 0 next. Two eng_start strobes at least 1025 cycles apart.
- CMD_RETRY_EN defined, MAX_RETRY=3, engine NACKs every attempt → 4 eng_start strobes, then a single err[owner], no done. NACK twice then ACK → 3 strobes, then done.
- CMD_RETRY_EN undefined, one NACK → err pulse after the first attempt, exactly 1 eng_start.
- TIMEOUT_CYC=100, engine never returns eng_done → eng_abort and err[owner] on the same cycle, 100 cycles after WAIT entry. A subsequent request is served normally.
- Assert rst_n=0 while in WAIT, then release → all outputs at reset values, no done/err pulse. A new req=2'b10 is granted to port 1.
